// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for the multicycle RV32I core: sequences fetch/decode/execute/
// memory/writeback and decodes all datapath selects and enables from the current state.
module multicycle_ctrl_fsm #(
   parameter int unsigned MEM_TIMEOUT = 1024
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [6:0] opcode,
   input  logic       branch_taken,
   input  logic       mem_ready,
   output logic [2:0] immsrc,
   output logic       mem_valid,
   output logic       mem_we,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] result_src,
   output logic [1:0] alu_op,
   output logic       illegal,
   output logic       bus_error
);

   localparam int unsigned CNT_W   = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam int unsigned TO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
   localparam bit          TO_EN   = (MEM_TIMEOUT > 0);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_J = 3'd3;
   localparam logic [2:0] IMM_U = 3'd4;

   localparam logic [1:0] A_PC = 2'd0, A_OLDPC = 2'd1, A_RS1 = 2'd2, A_ZERO = 2'd3;
   localparam logic [1:0] B_RS2 = 2'd0, B_IMM = 2'd1, B_FOUR = 2'd2;
   localparam logic [1:0] R_ALUOUT = 2'd0, R_RDATA = 2'd1, R_ALU = 2'd2;
   localparam logic [1:0] OP_ADD = 2'd0, OP_BRCMP = 2'd1, OP_FUNCT = 2'd2;

   typedef enum logic [4:0] {
      S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_JALR_ADR, S_JALR,
      S_LINKWB, S_LUI, S_AUIPC
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             in_mem;
   logic             timeout;

   // State and memory-wait counter registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_RESET;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state, state-decoded outputs and timeout counter update
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      immsrc     = IMM_I;
      mem_valid  = 1'b0;
      mem_we     = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = A_PC;
      alu_src_b  = B_RS2;
      result_src = R_ALUOUT;
      alu_op     = OP_ADD;
      illegal    = 1'b0;
      bus_error  = 1'b0;

      in_mem  = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
      timeout = TO_EN && in_mem && !mem_ready && (cnt_q == CNT_W'(TO_LAST));

      case (state_q)
         S_RESET: state_d = S_FETCH;
         S_FETCH: begin
            mem_valid  = 1'b1;
            alu_src_a  = A_PC;
            alu_src_b  = B_FOUR;
            result_src = R_ALU;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end else if (timeout) begin
               bus_error = 1'b1;
               state_d   = S_FETCH;
            end
         end
         S_DECODE: begin
            alu_src_a = A_OLDPC;
            alu_src_b = B_IMM;
            immsrc    = IMM_B;
            case (opcode)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_R:              state_d = S_EXEC_R;
               OP_I:              state_d = S_EXEC_I;
               OP_BRANCH:         state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               OP_JALR:           state_d = S_JALR_ADR;
               OP_LUI:            state_d = S_LUI;
               OP_AUIPC:          state_d = S_AUIPC;
               default: begin
                  illegal = 1'b1;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = A_RS1;
            alu_src_b = B_IMM;
            immsrc    = opcode[5] ? IMM_S : IMM_I;
            state_d   = opcode[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            mem_valid = 1'b1;
            adr_src   = 1'b1;
            if (mem_ready) begin
               state_d = S_MEMWB;
            end else if (timeout) begin
               bus_error = 1'b1;
               state_d   = S_FETCH;
            end
         end
         S_MEMWB: begin
            result_src = R_RDATA;
            reg_write  = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_valid = 1'b1;
            mem_we    = 1'b1;
            adr_src   = 1'b1;
            if (mem_ready) begin
               state_d = S_FETCH;
            end else if (timeout) begin
               bus_error = 1'b1;
               state_d   = S_FETCH;
            end
         end
         S_EXEC_R: begin
            alu_src_a = A_RS1;
            alu_src_b = B_RS2;
            alu_op    = OP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_EXEC_I: begin
            alu_src_a = A_RS1;
            alu_src_b = B_IMM;
            immsrc    = IMM_I;
            alu_op    = OP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            result_src = R_ALUOUT;
            reg_write  = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a  = A_RS1;
            alu_src_b  = B_RS2;
            alu_op     = OP_BRCMP;
            result_src = R_ALUOUT;
            pc_write   = branch_taken;
            state_d    = S_FETCH;
         end
         S_JAL: begin
            immsrc     = IMM_J;
            alu_src_a  = A_OLDPC;
            alu_src_b  = B_IMM;
            result_src = R_ALU;
            pc_write   = 1'b1;
            state_d    = S_LINKWB;
         end
         S_JALR_ADR: begin
            alu_src_a = A_RS1;
            alu_src_b = B_IMM;
            immsrc    = IMM_I;
            state_d   = S_JALR;
         end
         S_JALR: begin
            result_src = R_ALUOUT;
            pc_write   = 1'b1;
            state_d    = S_LINKWB;
         end
         S_LINKWB: begin
            alu_src_a  = A_OLDPC;
            alu_src_b  = B_FOUR;
            result_src = R_ALU;
            reg_write  = 1'b1;
            state_d    = S_FETCH;
         end
         S_LUI: begin
            immsrc    = IMM_U;
            alu_src_a = A_ZERO;
            alu_src_b = B_IMM;
            state_d   = S_ALUWB;
         end
         S_AUIPC: begin
            immsrc    = IMM_U;
            alu_src_a = A_OLDPC;
            alu_src_b = B_IMM;
            state_d   = S_ALUWB;
         end
         default: state_d = S_FETCH;
      endcase

      // Counter restarts on any state entry (including FETCH re-entry after a timeout)
      if ((state_d != state_q) || timeout) begin
         cnt_d = '0;
      end else if (TO_EN && in_mem && !mem_ready) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: stimulus queues expected per-cycle outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_multicycle_ctrl_fsm;

   typedef struct packed {
      logic [2:0] immsrc;
      logic       mem_valid, mem_we, adr_src, ir_write, pc_write, reg_write;
      logic [1:0] a, b, rs, op;
      logic       ill, be;
   } outs_t;

   logic       clk = 1'b0;
   logic       resetn;
   logic [6:0] opcode;
   logic       branch_taken;
   logic       mem_ready;
   logic [2:0] immsrc;
   logic       mem_valid, mem_we, adr_src, ir_write, pc_write, reg_write;
   logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
   logic       illegal, bus_error;

   outs_t exp_q[$];
   string tag_q[$];
   int    checks = 0;
   int    errors = 0;

   localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
   localparam logic [6:0] ADDI = 7'b0010011, BEQ = 7'b1100011, JAL = 7'b1101111;
   localparam logic [6:0] JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;
   localparam logic [6:0] SYS = 7'b1110011;

   multicycle_ctrl_fsm #(.MEM_TIMEOUT(8)) dut (
      .clk(clk), .resetn(resetn), .opcode(opcode), .branch_taken(branch_taken),
      .mem_ready(mem_ready), .immsrc(immsrc), .mem_valid(mem_valid), .mem_we(mem_we),
      .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
      .alu_op(alu_op), .illegal(illegal), .bus_error(bus_error)
   );

   always #5 clk = ~clk;

   function automatic outs_t mk(input logic [2:0] imm, input logic mv, we, adr, ir, pc, rw,
                                input logic [1:0] a, b, rs, op, input logic ill, be);
      mk = {imm, mv, we, adr, ir, pc, rw, a, b, rs, op, ill, be};
   endfunction

   // Hand-derived expected output vectors per state
   function automatic outs_t e_zero();      return mk(0,0,0,0,0,0,0, 0,0,0,0, 0,0); endfunction
   function automatic outs_t e_fetch(input logic r, input logic be);
      return mk(0,1,0,0,r,r,0, 0,2,2,0, 0,be);
   endfunction
   function automatic outs_t e_decode(input logic ill);
      return mk(2,0,0,0,0,0,0, 1,1,0,0, ill,0);
   endfunction
   function automatic outs_t e_memadr(input logic st);
      return mk(st ? 3'd1 : 3'd0,0,0,0,0,0,0, 2,1,0,0, 0,0);
   endfunction
   function automatic outs_t e_memread();   return mk(0,1,0,1,0,0,0, 0,0,0,0, 0,0); endfunction
   function automatic outs_t e_memwb();     return mk(0,0,0,0,0,0,1, 0,0,1,0, 0,0); endfunction
   function automatic outs_t e_memwrite();  return mk(0,1,1,1,0,0,0, 0,0,0,0, 0,0); endfunction
   function automatic outs_t e_exec_r();    return mk(0,0,0,0,0,0,0, 2,0,0,2, 0,0); endfunction
   function automatic outs_t e_exec_i();    return mk(0,0,0,0,0,0,0, 2,1,0,2, 0,0); endfunction
   function automatic outs_t e_aluwb();     return mk(0,0,0,0,0,0,1, 0,0,0,0, 0,0); endfunction
   function automatic outs_t e_branch(input logic tk);
      return mk(0,0,0,0,0,tk,0, 2,0,0,1, 0,0);
   endfunction
   function automatic outs_t e_jal();       return mk(3,0,0,0,0,1,0, 1,1,2,0, 0,0); endfunction
   function automatic outs_t e_jalr_adr();  return mk(0,0,0,0,0,0,0, 2,1,0,0, 0,0); endfunction
   function automatic outs_t e_jalr();      return mk(0,0,0,0,0,1,0, 0,0,0,0, 0,0); endfunction
   function automatic outs_t e_linkwb();    return mk(0,0,0,0,0,0,1, 1,2,2,0, 0,0); endfunction
   function automatic outs_t e_lui();       return mk(4,0,0,0,0,0,0, 3,1,0,0, 0,0); endfunction
   function automatic outs_t e_auipc();     return mk(4,0,0,0,0,0,0, 1,1,0,0, 0,0); endfunction

   task automatic step(input logic rn, input logic [6:0] op, input logic br, input logic rdy,
                       input outs_t e, input string tag);
      resetn       = rn;
      opcode       = op;
      branch_taken = br;
      mem_ready    = rdy;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
   endtask

   // Monitor: every cycle the FSM presents a decoded output vector
   always @(negedge clk) begin
      outs_t act, exp;
      string tag;
      if (exp_q.size() != 0) begin
         exp = exp_q.pop_front();
         tag = tag_q.pop_front();
         act = {immsrc, mem_valid, mem_we, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, result_src, alu_op, illegal, bus_error};
         checks++;
         if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, act, exp, $time);
         end
      end
   end

   initial begin
      resetn = 1'b0; opcode = ADDI; branch_taken = 1'b0; mem_ready = 1'b1;
      @(posedge clk);
      #1;
      step(0, ADDI, 0, 1, e_zero(), "reset0");
      step(0, ADDI, 0, 1, e_zero(), "reset1");
      step(1, ADDI, 0, 1, e_zero(), "reset_release");
      // ADDI with mem_ready tied high
      step(1, ADDI, 0, 1, e_fetch(1, 0), "addi_fetch");
      step(1, ADDI, 0, 1, e_decode(0),   "addi_decode");
      step(1, ADDI, 0, 1, e_exec_i(),    "addi_exec_i");
      step(1, ADDI, 0, 1, e_aluwb(),     "addi_aluwb");
      // LW with three wait cycles
      step(1, LW, 0, 1, e_fetch(1, 0), "lw_fetch");
      step(1, LW, 0, 1, e_decode(0),   "lw_decode");
      step(1, LW, 0, 1, e_memadr(0),   "lw_memadr");
      step(1, LW, 0, 0, e_memread(),   "lw_memread_w1");
      step(1, LW, 0, 0, e_memread(),   "lw_memread_w2");
      step(1, LW, 0, 0, e_memread(),   "lw_memread_w3");
      step(1, LW, 0, 1, e_memread(),   "lw_memread_rdy");
      step(1, LW, 0, 1, e_memwb(),     "lw_memwb");
      // SW
      step(1, SW, 0, 1, e_fetch(1, 0), "sw_fetch");
      step(1, SW, 0, 1, e_decode(0),   "sw_decode");
      step(1, SW, 0, 1, e_memadr(1),   "sw_memadr");
      step(1, SW, 0, 1, e_memwrite(),  "sw_memwrite");
      // BEQ taken / not taken
      step(1, BEQ, 1, 1, e_fetch(1, 0), "beq_t_fetch");
      step(1, BEQ, 1, 1, e_decode(0),   "beq_t_decode");
      step(1, BEQ, 1, 1, e_branch(1),   "beq_taken");
      step(1, BEQ, 0, 1, e_fetch(1, 0), "beq_n_fetch");
      step(1, BEQ, 0, 1, e_decode(0),   "beq_n_decode");
      step(1, BEQ, 0, 1, e_branch(0),   "beq_not_taken");
      // JAL, JALR
      step(1, JAL, 0, 1, e_fetch(1, 0), "jal_fetch");
      step(1, JAL, 0, 1, e_decode(0),   "jal_decode");
      step(1, JAL, 0, 1, e_jal(),       "jal_jal");
      step(1, JAL, 0, 1, e_linkwb(),    "jal_linkwb");
      step(1, JALR, 0, 1, e_fetch(1, 0), "jalr_fetch");
      step(1, JALR, 0, 1, e_decode(0),   "jalr_decode");
      step(1, JALR, 0, 1, e_jalr_adr(),  "jalr_adr");
      step(1, JALR, 0, 1, e_jalr(),      "jalr_jalr");
      step(1, JALR, 0, 1, e_linkwb(),    "jalr_linkwb");
      // R-type, LUI, AUIPC
      step(1, RT, 0, 1, e_fetch(1, 0), "r_fetch");
      step(1, RT, 0, 1, e_decode(0),   "r_decode");
      step(1, RT, 0, 1, e_exec_r(),    "r_exec_r");
      step(1, RT, 0, 1, e_aluwb(),     "r_aluwb");
      step(1, LUI, 0, 1, e_fetch(1, 0), "lui_fetch");
      step(1, LUI, 0, 1, e_decode(0),   "lui_decode");
      step(1, LUI, 0, 1, e_lui(),       "lui_lui");
      step(1, LUI, 0, 1, e_aluwb(),     "lui_aluwb");
      step(1, AUIPC, 0, 1, e_fetch(1, 0), "auipc_fetch");
      step(1, AUIPC, 0, 1, e_decode(0),   "auipc_decode");
      step(1, AUIPC, 0, 1, e_auipc(),     "auipc_auipc");
      step(1, AUIPC, 0, 1, e_aluwb(),     "auipc_aluwb");
      // Unsupported SYSTEM opcode
      step(1, SYS, 0, 1, e_fetch(1, 0), "sys_fetch");
      step(1, SYS, 0, 1, e_decode(1),   "sys_illegal");
      // Fetch timeout: error on 8th stalled cycle, then restart; ready on 8th cycle wins
      for (int i = 0; i < 7; i++) step(1, ADDI, 0, 0, e_fetch(0, 0), "to_wait");
      step(1, ADDI, 0, 0, e_fetch(0, 1), "to_bus_error");
      for (int i = 0; i < 7; i++) step(1, ADDI, 0, 0, e_fetch(0, 0), "to_restart_wait");
      step(1, ADDI, 0, 1, e_fetch(1, 0), "to_ready_wins");
      step(1, ADDI, 0, 1, e_decode(0),   "to_decode");
      step(1, ADDI, 0, 1, e_exec_i(),    "to_exec_i");
      step(1, ADDI, 0, 1, e_aluwb(),     "to_aluwb");
      // Reset asserted mid-MEMWRITE while stalled
      step(1, SW, 0, 1, e_fetch(1, 0), "rst_sw_fetch");
      step(1, SW, 0, 1, e_decode(0),   "rst_sw_decode");
      step(1, SW, 0, 1, e_memadr(1),   "rst_sw_memadr");
      step(1, SW, 0, 0, e_memwrite(),  "rst_sw_memwrite");
      step(0, SW, 0, 0, e_zero(),      "rst_async_zero");
      step(0, SW, 0, 1, e_zero(),      "rst_held");
      step(1, ADDI, 0, 1, e_zero(),    "rst_release2");
      step(1, ADDI, 0, 1, e_fetch(1, 0), "rst_refetch");
      step(1, ADDI, 0, 1, e_decode(0),   "rst_redecode");

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
